// File: rtl/ltf_ctrl_pkg.sv
// ltf_ctrl_pkg: shared types and width helpers for the LTF window controller.
// Provides the sequencer state enum, status counter widths, default parameter
// values and a helper that sizes a modulo-N phase counter.
package ltf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } ltf_state_t;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned DROP_CNT_W  = 8;

  localparam int unsigned DEF_TDATA_W  = 32;
  localparam int unsigned DEF_SKIP     = 32;
  localparam int unsigned DEF_CAPTURE  = 128;
  localparam int unsigned DEF_HOLDOFF  = 320;
  localparam int unsigned DEF_TIMEOUT  = 256;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ltf_window_ctrl_axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream output register.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load_c              load a new beat this cycle (caller guarantees ready_c)
//   load_data/load_last beat payload
//   m_tready            downstream ready
//   m_tvalid/m_tdata/m_tlast  registered output beat
//   ready_c             register can take a beat this cycle (empty or draining)
module axis_out_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_c,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_tready,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  output logic             ready_c
);

  assign ready_c = m_tready || !m_tvalid;

  // Load wins over drain so back-to-back beats run at one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (load_c) begin
      m_tvalid <= 1'b1;
      m_tdata  <= load_data;
      m_tlast  <= load_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/ltf_window_ctrl.sv
// ltf_window_ctrl: gates the I/Q sample stream into LTF capture windows.
// A trigger pulse arms the sequencer; it discards SKIP_SAMPLES accepted
// samples, forwards CAPTURE_SAMPLES samples as one AXI-Stream frame ending in
// tlast, then ignores retriggers for HOLDOFF_SAMPLES accepted samples.
// Optional: define LTF_WINDOW_TIMEOUT_EN to abort SKIP after TIMEOUT_CYCLES
// consecutive cycles without an accepted sample (abort_o pulses).
// Ports:
//   s00_axis_aclk, s00_axis_aresetn   clock, async active-low reset
//   s00_axis_tvalid/tdata/tready      input sample stream
//   trig_in                           packet-detect pulse
//   m00_axis_tvalid/tdata/tlast/tready output window stream
//   busy                              sequencer not idle
//   frame_count                       completed frames (wraps)
//   drop_count                        ignored triggers (saturates)
//   abort_o                           SKIP timeout abort pulse
module ltf_window_ctrl
  import ltf_ctrl_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = DEF_TDATA_W,
  parameter int unsigned SKIP_SAMPLES           = DEF_SKIP,
  parameter int unsigned CAPTURE_SAMPLES        = DEF_CAPTURE,
  parameter int unsigned HOLDOFF_SAMPLES        = DEF_HOLDOFF,
  parameter int unsigned TIMEOUT_CYCLES         = DEF_TIMEOUT
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  output logic                              s00_axis_tready,
  input  logic                              trig_in,
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  output logic                              busy,
  output logic [FRAME_CNT_W-1:0]            frame_count,
  output logic [DROP_CNT_W-1:0]             drop_count,
  output logic                              abort_o
);

  localparam int unsigned CNT_W     = cnt_width(max3(SKIP_SAMPLES, CAPTURE_SAMPLES,
                                                     HOLDOFF_SAMPLES));
  localparam int unsigned SKIP_LAST = SKIP_SAMPLES - 1;
  localparam int unsigned CAP_LAST  = CAPTURE_SAMPLES - 1;
  localparam int unsigned HOLD_LAST = (HOLDOFF_SAMPLES > 0) ? HOLDOFF_SAMPLES - 1 : 0;

  // Reject configurations the counters cannot represent.
  if (SKIP_SAMPLES == 0 || CAPTURE_SAMPLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("ltf_window_ctrl: SKIP_SAMPLES, CAPTURE_SAMPLES and TIMEOUT_CYCLES must be >= 1");
  end

  wire clk   = s00_axis_aclk;
  wire rst_n = s00_axis_aresetn;

  ltf_state_t       state, state_nxt;
  logic [CNT_W-1:0] samp_cnt, samp_cnt_nxt;
  logic             accept_c;
  logic             out_ready_c;
  logic             load_c;
  logic             load_last_c;
  logic             abort_nxt_c;

  // Output register owns the downstream handshake; FSM only issues loads.
  axis_out_reg #(
    .WIDTH (C_S00_AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_c    (load_c),
    .load_data (s00_axis_tdata),
    .load_last (load_last_c),
    .m_tready  (m00_axis_tready),
    .m_tvalid  (m00_axis_tvalid),
    .m_tdata   (m00_axis_tdata),
    .m_tlast   (m00_axis_tlast),
    .ready_c   (out_ready_c)
  );

  // Backpressure only matters while samples are being forwarded.
  assign s00_axis_tready = (state == ST_CAPTURE) ? out_ready_c : 1'b1;
  assign accept_c        = s00_axis_tvalid && s00_axis_tready;

`ifdef LTF_WINDOW_TIMEOUT_EN
  localparam int unsigned TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned TO_LAST = TIMEOUT_CYCLES - 1;

  logic [TO_W-1:0] stall_cnt;
  logic            stall_hit_c;

  // Consecutive SKIP cycles without an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == ST_SKIP && !accept_c) begin
      stall_cnt <= stall_cnt + TO_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

  assign stall_hit_c = (stall_cnt == TO_W'(TO_LAST));
`else
  logic stall_hit_c;
  assign stall_hit_c = 1'b0;
`endif

  // State and phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      samp_cnt <= '0;
    end else begin
      state    <= state_nxt;
      samp_cnt <= samp_cnt_nxt;
    end
  end

  // Next-state, phase counter and load control.
  always_comb begin
    state_nxt    = state;
    samp_cnt_nxt = samp_cnt;
    load_c       = 1'b0;
    load_last_c  = 1'b0;
    abort_nxt_c  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A sample accepted alongside the trigger is not part of the skip.
        samp_cnt_nxt = '0;
        if (trig_in) state_nxt = ST_SKIP;
      end
      ST_SKIP: begin
        if (accept_c) begin
          if (samp_cnt == CNT_W'(SKIP_LAST)) begin
            samp_cnt_nxt = '0;
            state_nxt    = ST_CAPTURE;
          end else begin
            samp_cnt_nxt = samp_cnt + CNT_W'(1);
          end
        end else if (stall_hit_c) begin
          samp_cnt_nxt = '0;
          state_nxt    = ST_IDLE;
          abort_nxt_c  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (accept_c) begin
          load_c = 1'b1;
          if (samp_cnt == CNT_W'(CAP_LAST)) begin
            load_last_c  = 1'b1;
            samp_cnt_nxt = '0;
            state_nxt    = (HOLDOFF_SAMPLES == 0) ? ST_IDLE : ST_HOLDOFF;
          end else begin
            samp_cnt_nxt = samp_cnt + CNT_W'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (accept_c) begin
          if (samp_cnt == CNT_W'(HOLD_LAST)) begin
            samp_cnt_nxt = '0;
            state_nxt    = ST_IDLE;
          end else begin
            samp_cnt_nxt = samp_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        samp_cnt_nxt = '0;
        state_nxt    = ST_IDLE;
      end
    endcase
  end

  // Status: busy follows the next state so it rises the cycle after a trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end
      if (trig_in && state != ST_IDLE && drop_count != '1) begin
        drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end
  end

`ifdef LTF_WINDOW_TIMEOUT_EN
  // One-cycle abort pulse on SKIP timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_o <= 1'b0;
    end else begin
      abort_o <= abort_nxt_c;
    end
  end
`else
  assign abort_o = 1'b0;
  logic unused_abort_c;
  assign unused_abort_c = abort_nxt_c;
`endif

endmodule

// File: doc/ltf_window_ctrl.md
# ltf_window_ctrl

Sequencer that sits between the sample delay line and the CSI extractor datapath and gates the 32-bit I/Q sample stream into LTF capture windows. A single-cycle detection pulse from the packet detector arms it. It then discards a fixed number of samples (cyclic prefix / alignment), forwards a fixed-length window downstream as one AXI-Stream frame terminated by `tlast`, and ignores retriggers for a hold-off period.

## Interface
Parameters:
- `C_S00_AXIS_TDATA_WIDTH`, default 32: sample width (I/Q packed).
- `SKIP_SAMPLES`, default 32: accepted samples discarded after trigger. Must be ≥1.
- `CAPTURE_SAMPLES`, default 128: samples forwarded per frame. Must be ≥1.
- `HOLDOFF_SAMPLES`, default 320: accepted samples after a frame during which triggers are ignored. 0 is allowed.
- `TIMEOUT_CYCLES`, default 256: SKIP stall limit. Used only with the macro.

Ports:
- `s00_axis_aclk`  in  1  clock.
- `s00_axis_aresetn`  in  1  reset; asynchronous, active-low.
- `s00_axis_tvalid`  in  1  input sample valid.
- `s00_axis_tdata`  in  C_S00_AXIS_TDATA_WIDTH  input sample.
- `s00_axis_tready`  out  1  input ready.
- `trig_in`  in  1  packet-detect pulse, one cycle.
- `m00_axis_tready`  in  1  downstream ready.
- `m00_axis_tvalid`  out  1  output beat valid.
- `m00_axis_tdata`  out  C_S00_AXIS_TDATA_WIDTH  output sample.
- `m00_axis_tlast`  out  1  last beat of window.
- `busy`  out  1  high when state ≠ IDLE.
- `frame_count`  out  16  completed frames; wraps.
- `drop_count`  out  8  ignored triggers; saturates at 255.
- `abort_o`  out  1  one-cycle timeout abort pulse. Tied 0 without the macro.

## Operation
- States: IDLE, SKIP, CAPTURE, HOLDOFF. Reset state is IDLE.
- Accepted sample = `s00_axis_tvalid && s00_axis_tready`. All counters advance only on accepted samples.
- `s00_axis_tready`:
  - IDLE, SKIP, HOLDOFF: 1. Samples are consumed and discarded.
  - CAPTURE: `m00_axis_tready || ~m00_axis_tvalid`.
- IDLE:
  - `trig_in` → SKIP.
  - The skip counter clears.
  - A sample accepted in the trigger cycle is discarded and not counted.
- SKIP: after `SKIP_SAMPLES` accepted samples → CAPTURE.
- CAPTURE:
  - Each accepted sample is loaded into the output register.
  - The `CAPTURE_SAMPLES`-th sample loads with `tlast=1`; state → HOLDOFF on that same cycle.
- HOLDOFF:
  - After `HOLDOFF_SAMPLES` accepted samples → IDLE.
  - If `HOLDOFF_SAMPLES`=0, CAPTURE goes directly to IDLE.
  - The pending output beat drains independently of state.
- `trig_in` in any state other than IDLE increments `drop_count`, saturating. It is otherwise ignored.
- `frame_count` increments on the output handshake of a beat with `tlast=1`.
- Output register holds `tdata`/`tlast` stable while `m00_axis_tvalid && ~m00_axis_tready`. No beat is dropped or duplicated.
- Reset, including mid-operation, asynchronously forces:
  - `m00_axis_tvalid`, `m00_axis_tlast`, `m00_axis_tdata`, `busy`, `abort_o`, all counters: 0.
  - `s00_axis_tready`: 1.
  - State: IDLE. Any partial frame is lost.

## Timing
- Trigger at cycle t → `busy`=1 at t+1.
- Latency: capture sample accepted at cycle c → `m00_axis_tvalid`=1 with that data at c+1.
- With continuous input and `m00_axis_tready`=1:
  - Output window covers input samples SKIP+1 … SKIP+CAPTURE after the trigger cycle.
  - Throughput is one beat per cycle.
- `m00_axis_tvalid` deasserts the cycle after a handshake unless a new sample loads on that same cycle.

## Configuration
- `LTF_WINDOW_TIMEOUT_EN` defined:
  - In SKIP, a cycle counter counts consecutive cycles with no accepted sample; it clears on each accepted sample.
  - On reaching `TIMEOUT_CYCLES`: state → IDLE and `abort_o` pulses for one cycle.
  - No output beat exists in SKIP, so abort never truncates a frame.
  - CAPTURE and HOLDOFF are never aborted.
- Undefined: no timeout logic. SKIP waits indefinitely. `abort_o` is constant 0.

## Structure
- Package `ltf_ctrl_pkg`:
  - State enum `ltf_state_t`.
  - Count width constants derived via `$clog2` of the parameters.
  - Status widths (16/8).
- Sub-module `axis_out_reg`: single-entry output register with valid/ready/last. Keeps the handshake logic out of the FSM.

## Test plan
- Defaults; continuous input of samples numbered 0,1,2…; trigger coincident with sample 10 → 128 beats carrying samples 43…170, `tlast` on 170 only, `frame_count`=1, `busy` falls after 320 more samples.
- `m00_axis_tready` pseudo-random at 50% during CAPTURE → `s00_axis_tready` low exactly when the output is stalled, output sequence identical to the first scenario, no gaps or duplicates.
- Triggers during SKIP, CAPTURE and HOLDOFF of one frame → `drop_count`=3, exactly one frame emitted. Then 300 extra triggers → `drop_count`=255.
- `HOLDOFF_SAMPLES`=0, trigger on the cycle after the `tlast` input is accepted → second frame starts cleanly, `frame_count`=2.
- Reset asserted mid-CAPTURE after 50 beats → all outputs 0 in the same cycle, `busy`=0. The next trigger yields a full 128-beat frame.
- Macro defined, `TIMEOUT_CYCLES`=256, trigger then `tvalid` low for 1000 cycles → `abort_o` pulses once after 256 stall cycles, state IDLE, no output beats. Macro undefined → `busy` stays 1.
